// File: rtl/mux_sel_scheduler.sv
// mux_sel_scheduler: round-robin owner of a shared mux/demux path with guard gap; SCHED_DWELL_LIMIT_EN caps hold time.
module mux_sel_scheduler #(
  parameter int N         = 4,
  parameter int SEL_W     = 2,
  parameter int GUARD     = 1,
  parameter int MAX_DWELL = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     req,
  output logic [N-1:0]     grant,
  output logic [SEL_W-1:0] sel,
  output logic             en,
  output logic             busy,
  output logic             preempt
);
`ifdef SCHED_DWELL_LIMIT_EN
  localparam bit LIMIT = 1'b1;
`else
  localparam bit LIMIT = 1'b0;
`endif
  typedef enum logic [1:0] {S_IDLE, S_GRANT, S_GUARD} state_t;
  state_t state, state_n;
  logic [N-1:0] grant_n;
  logic [SEL_W-1:0] sel_n, ptr, ptr_n, w, c;
  logic [7:0] dwell, dwell_n;
  logic [3:0] gcnt, gcnt_n;
  logic preempt_n, found, force_rel, rel, go;
  always_comb begin
    found = 1'b0;
    w = '0;
    c = '0;
    for (int i = 0; i < N; i++) begin
      c = SEL_W'((int'(ptr) + i) % N);
      if (!found && req[c]) begin
        found = 1'b1;
        w = c;
      end
    end
  end
  assign force_rel = LIMIT && dwell == 8'(MAX_DWELL) && req[sel];
  assign rel = !req[sel] || force_rel;
  always_comb begin
    state_n = state;
    grant_n = grant;
    sel_n = sel;
    ptr_n = ptr;
    dwell_n = dwell;
    gcnt_n = gcnt;
    preempt_n = 1'b0;
    go = 1'b0;
    case (state)
      S_IDLE: go = 1'b1;
      S_GRANT: begin
        if (rel) begin
          grant_n = '0;
          dwell_n = '0;
          preempt_n = force_rel;
          if (GUARD > 0) begin
            state_n = S_GUARD;
            gcnt_n = 4'(GUARD - 1);
          end else go = 1'b1;
        end else dwell_n = dwell + {7'd0, dwell != 8'hff};
      end
      S_GUARD: begin
        if (gcnt == '0) go = 1'b1;
        else gcnt_n = gcnt - 4'd1;
      end
      default: state_n = S_IDLE;
    endcase
    // arbitration shared by IDLE, end of GUARD and zero-guard release
    if (go) begin
      state_n = found ? S_GRANT : S_IDLE;
      if (found) begin
        grant_n = {{(N-1){1'b0}}, 1'b1} << w;
        sel_n = w;
        dwell_n = 8'd1;
        ptr_n = (w == SEL_W'(N - 1)) ? '0 : w + 1'b1;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      grant <= '0;
      sel <= '0;
      ptr <= '0;
      dwell <= '0;
      gcnt <= '0;
      preempt <= 1'b0;
    end else begin
      state <= state_n;
      grant <= grant_n;
      sel <= sel_n;
      ptr <= ptr_n;
      dwell <= dwell_n;
      gcnt <= gcnt_n;
      preempt <= preempt_n;
    end
  end
  assign en = |grant;
  assign busy = state != S_IDLE;
endmodule

// File: tb/tb_mux_sel_scheduler.sv
// tb_mux_sel_scheduler: directed checks of the scheduler with GUARD=1 and a second GUARD=0 instance.
module tb_mux_sel_scheduler;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [3:0] req = 4'b1111, req2 = 4'b0000;
  logic [3:0] grant, grant2;
  logic [1:0] sel, sel2;
  logic en, busy, preempt, en2, busy2, preempt2;
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  mux_sel_scheduler #(.N(4), .SEL_W(2), .GUARD(1), .MAX_DWELL(16)) u_dut (
    .clk(clk), .rst(rst), .req(req), .grant(grant), .sel(sel),
    .en(en), .busy(busy), .preempt(preempt)
  );
  mux_sel_scheduler #(.N(4), .SEL_W(2), .GUARD(0), .MAX_DWELL(16)) u_g0 (
    .clk(clk), .rst(rst), .req(req2), .grant(grant2), .sel(sel2),
    .en(en2), .busy(busy2), .preempt(preempt2)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic drop_restore(input logic [3:0] during, input logic [3:0] after);
    req = during;
    @(negedge clk);
    check("guard_en", 32'(en), 0);
    check("guard_busy", 32'(busy), 1);
    req = after;
    @(negedge clk);
  endtask
  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_grant", 32'(grant), 0);
    check("rst_sel", 32'(sel), 0);
    check("rst_en", 32'(en), 0);
    check("rst_busy", 32'(busy), 0);
    rst = 1'b0;
    @(negedge clk);
    check("first_grant", 32'(grant), 32'h1);
    check("first_sel", 32'(sel), 0);
    check("first_en", 32'(en), 1);
    for (int k = 0; k < 4; k++) begin
      repeat (2) @(negedge clk);
      check("rr_hold", 32'(grant), 32'(1 << k));
      req[k] = 1'b0;
      @(negedge clk);
      check("rr_gap_en", 32'(en), 0);
      check("rr_gap_sel", 32'(sel), 32'(k));
      req[k] = 1'b1;
      @(negedge clk);
      check("rr_next", 32'(grant), 32'(1 << ((k + 1) % 4)));
      check("rr_next_sel", 32'(sel), 32'((k + 1) % 4));
    end
    drop_restore(4'b0100, 4'b0100);
    check("wrap_ch2", 32'(grant), 32'h4);
    drop_restore(4'b0001, 4'b0101);
    check("wrap_ch0", 32'(grant), 32'h1);
    drop_restore(4'b0100, 4'b0101);
    check("skip_ch2", 32'(grant), 32'h4);
    drop_restore(4'b0001, 4'b0101);
    check("skip_ch0", 32'(grant), 32'h1);
    drop_restore(4'b0100, 4'b0101);
    check("mid_ch2", 32'(grant), 32'h4);
    repeat (4) @(negedge clk);
    check("mid_hold", 32'(grant), 32'h4);
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_grant", 32'(grant), 0);
    check("mid_rst_sel", 32'(sel), 0);
    check("mid_rst_en", 32'(en), 0);
    check("mid_rst_busy", 32'(busy), 0);
    check("mid_rst_pre", 32'(preempt), 0);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_grant", 32'(grant), 32'h1);
    check("post_rst_sel", 32'(sel), 0);
    drop_restore(4'b1000, 4'b1000);
    check("lone_grant", 32'(grant), 32'h8);
    for (int r = 0; r < 2; r++) begin
      repeat (15) @(negedge clk);
      check("lone_c16", 32'(grant), 32'h8);
      @(negedge clk);
`ifdef SCHED_DWELL_LIMIT_EN
      check("lone_cut_grant", 32'(grant), 0);
      check("lone_cut_pre", 32'(preempt), 1);
      check("lone_cut_busy", 32'(busy), 1);
`else
      check("lone_keep_grant", 32'(grant), 32'h8);
      check("lone_keep_pre", 32'(preempt), 0);
`endif
      @(negedge clk);
      check("lone_regrant", 32'(grant), 32'h8);
      check("lone_pre_low", 32'(preempt), 0);
    end
    req = 4'b0000;
    req2 = 4'b0010;
    @(negedge clk);
    check("g0_ch1", 32'(grant2), 32'h2);
    check("g0_sel1", 32'(sel2), 1);
    req2 = 4'b0100;
    @(negedge clk);
    check("g0_ch2", 32'(grant2), 32'h4);
    check("g0_sel2", 32'(sel2), 2);
    check("g0_en", 32'(en2), 1);
    req2 = 4'b0000;
    @(negedge clk);
    check("g0_idle_grant", 32'(grant2), 0);
    check("g0_idle_en", 32'(en2), 0);
    check("g0_idle_busy", 32'(busy2), 0);
    check("g0_sel_hold", 32'(sel2), 2);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
